// File: rtl/dm_pkg.sv
// Shared encodings, FSM states and legality rules for the data-memory
// access sequencer.
package dm_pkg;

    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_HS = 3'd1;
    localparam logic [2:0] DM_BS = 3'd2;
    localparam logic [2:0] DM_HU = 3'd3;
    localparam logic [2:0] DM_BU = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_RESP
    } dm_state_t;

    // Unsigned sub-word types exist only for loads.
    function automatic logic dm_legal(
        input logic       we,
        input logic [2:0] typ,
        input logic [1:0] lo
    );
        logic ok;
        case (typ)
            DM_W:    ok = (lo == 2'b00);
            DM_HS:   ok = !lo[0];
            DM_BS:   ok = 1'b1;
            DM_HU:   ok = !lo[0] && !we;
            DM_BU:   ok = !we;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// Byte-lane merge for sub-word stores and field extraction for loads,
// both keyed on the low two address bits.
module dm_lane_merge
    import dm_pkg::*;
(
    input  logic [2:0]  req_type,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] merged_word,
    output logic [31:0] load_ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'h00;
        unique case (off)
            2'd0: byte_v = old_word[7:0];
            2'd1: byte_v = old_word[15:8];
            2'd2: byte_v = old_word[23:16];
            2'd3: byte_v = old_word[31:24];
        endcase
        half_v = off[1] ? old_word[31:16] : old_word[15:0];
    end

    always_comb begin
        merged_word = old_word;
        case (req_type)
            DM_W: merged_word = wdata;
            DM_HS, DM_HU: begin
                if (off[1]) merged_word[31:16] = wdata[15:0];
                else        merged_word[15:0]  = wdata[15:0];
            end
            DM_BS, DM_BU: begin
                unique case (off)
                    2'd0: merged_word[7:0]   = wdata[7:0];
                    2'd1: merged_word[15:8]  = wdata[7:0];
                    2'd2: merged_word[23:16] = wdata[7:0];
                    2'd3: merged_word[31:24] = wdata[7:0];
                endcase
            end
            default: merged_word = old_word;
        endcase
    end

    always_comb begin
        load_ext = 32'h0;
        case (req_type)
            DM_W:    load_ext = old_word;
            DM_HS:   load_ext = {{16{half_v[15]}}, half_v};
            DM_BS:   load_ext = {{24{byte_v[7]}}, byte_v};
            DM_HU:   load_ext = {16'h0, half_v};
            DM_BU:   load_ext = {24'h0, byte_v};
            default: load_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/dm_access_seq.sv
// Sequences MIPS data-memory requests onto a single-port synchronous RAM,
// using read-modify-write for sub-word stores.
module dm_access_seq
    import dm_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [2:0]        req_type,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    dm_state_t         state;
    logic              we_q;
    logic [ADDR_W+1:0] addr_q;
    logic [2:0]        type_q;
    logic [31:0]       wdata_q;
    logic [31:0]       old_q;
    logic [31:0]       merged_word;
    logic [31:0]       load_ext;
    logic [31:0]       old_sel;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
    assign req_ready      = (state == S_IDLE) && !reset;

    // RAM data is only valid during WAIT; afterwards the captured copy is used.
    assign old_sel = (state == S_WAIT) ? mem_rdata : old_q;

    dm_lane_merge u_merge (
        .req_type    (type_q),
        .off         (addr_q[1:0]),
        .wdata       (wdata_q),
        .old_word    (old_sel),
        .merged_word (merged_word),
        .load_ext    (load_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            type_q    <= 3'd0;
            wdata_q   <= 32'h0;
            old_q     <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr[ADDR_W+1:0];
                        type_q    <= req_type;
                        wdata_q   <= req_wdata;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                        mem_addr  <= req_addr[ADDR_W+1:2];
                        if (!dm_legal(req_we, req_type, req_addr[1:0])) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else if (req_we && req_type == DM_W) begin
                            mem_en    <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= req_wdata;
                            state     <= S_WRITE;
                        end else begin
                            mem_en <= 1'b1;
                            state  <= S_READ;
                        end
                    end
                end
                S_READ: state <= S_WAIT;
                S_WAIT: begin
                    old_q <= mem_rdata;
                    if (we_q) begin
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= merged_word;
                        state     <= S_WRITE;
                    end else begin
                        rsp_rdata <= load_ext;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_WRITE: begin
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_seq.sv
// Directed bench for dm_access_seq: vector table plus reset corner cases,
// with a behavioural synchronous-read RAM.
module tb_dm_access_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_type;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] ram [0:4095];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dm_access_seq #(.ADDR_W(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_type  (req_type),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  typ;
        logic [31:0] wdata;
        logic        pre_en;
        logic [31:0] pre;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          lat;
        logic [31:0] exp_ram;
    } vec_t;

    vec_t vec [16];

    task automatic run_req(input int n, input vec_t v);
        int got, en_cnt, we_cnt;
        logic [31:0] rd;
        logic err;
        logic [11:0] idx;
        idx = v.addr[13:2];
        if (v.pre_en) ram[idx] = v.pre;
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_type  = v.typ;
        req_wdata = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5555_5555;
        req_type  = 3'd7;
        req_we    = ~v.we;
        got = 0; en_cnt = 0; we_cnt = 0; rd = 32'h0; err = 1'b0;
        for (int c = 1; c <= 10 && got == 0; c++) begin
            @(negedge clk);
            if (mem_en) en_cnt++;
            if (mem_we) we_cnt++;
            if (rsp_valid) begin
                got = c;
                rd  = rsp_rdata;
                err = rsp_err;
            end
        end
        @(negedge clk);
        chk($sformatf("v%0d latency", n), got, v.lat);
        chk($sformatf("v%0d rdata", n), rd, v.exp_rd);
        chk($sformatf("v%0d err", n), {31'h0, err}, {31'h0, v.exp_err});
        chk($sformatf("v%0d pulse_end", n), {31'h0, rsp_valid}, 32'h0);
        chk($sformatf("v%0d ready_after", n), {31'h0, req_ready}, 32'h1);
        chk($sformatf("v%0d mem_en_cycles", n), en_cnt,
            (v.lat == 1) ? 0 : (v.lat == 4) ? 2 : 1);
        chk($sformatf("v%0d mem_we_cycles", n), we_cnt,
            (v.lat == 2 || v.lat == 4) ? 1 : 0);
        chk($sformatf("v%0d ram", n), ram[idx], v.exp_ram);
    endtask

    initial begin
        int bad_we, bad_rsp;
        vec_t v;
        for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
        mem_rdata = 32'h0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = 32'h0;
        req_type = 3'd0;
        req_wdata = 32'h0;

        vec[0]  = '{1, 32'h10, 3'd0, 32'hDEADBEEF, 1, 32'h0, 32'h0, 0, 2, 32'hDEADBEEF};
        vec[1]  = '{0, 32'h10, 3'd0, 32'h0, 0, 32'h0, 32'hDEADBEEF, 0, 3, 32'hDEADBEEF};
        vec[2]  = '{1, 32'h12, 3'd2, 32'hAA, 1, 32'h11223344, 32'h0, 0, 4, 32'h11AA3344};
        vec[3]  = '{1, 32'h12, 3'd1, 32'hBEEF, 1, 32'h11223344, 32'h0, 0, 4, 32'hBEEF3344};
        vec[4]  = '{0, 32'h12, 3'd2, 32'h0, 1, 32'h80FF7F01, 32'hFFFFFFFF, 0, 3, 32'h80FF7F01};
        vec[5]  = '{0, 32'h12, 3'd4, 32'h0, 1, 32'h80FF7F01, 32'h000000FF, 0, 3, 32'h80FF7F01};
        vec[6]  = '{0, 32'h12, 3'd1, 32'h0, 1, 32'h80FF7F01, 32'hFFFF80FF, 0, 3, 32'h80FF7F01};
        vec[7]  = '{0, 32'h10, 3'd3, 32'h0, 1, 32'h80FF7F01, 32'h00007F01, 0, 3, 32'h80FF7F01};
        vec[8]  = '{0, 32'h12, 3'd3, 32'h0, 1, 32'h80FF7F01, 32'h000080FF, 0, 3, 32'h80FF7F01};
        vec[9]  = '{1, 32'h11, 3'd1, 32'hBEEF, 1, 32'h01020304, 32'h0, 1, 1, 32'h01020304};
        vec[10] = '{1, 32'h12, 3'd0, 32'hCAFE0000, 1, 32'h01020304, 32'h0, 1, 1, 32'h01020304};
        vec[11] = '{1, 32'h10, 3'd4, 32'h77, 1, 32'h01020304, 32'h0, 1, 1, 32'h01020304};
        vec[12] = '{0, 32'h10, 3'd5, 32'h0, 1, 32'h01020304, 32'h0, 1, 1, 32'h01020304};
        vec[13] = '{1, 32'h13, 3'd2, 32'h123456CC, 1, 32'h0, 32'h0, 0, 4, 32'hCC000000};
        vec[14] = '{0, 32'h13, 3'd2, 32'h0, 1, 32'h7F000000, 32'h0000007F, 0, 3, 32'h7F000000};
        vec[15] = '{1, 32'hFFFF0014, 3'd0, 32'h0BADF00D, 1, 32'h0, 32'h0, 0, 2, 32'h0BADF00D};

        #12;
        chk("rst req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst rsp_rdata", rsp_rdata, 32'h0);
        chk("rst mem_en", {31'h0, mem_en}, 32'h0);
        chk("rst mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst mem_addr", {20'h0, mem_addr}, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle req_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 16; i++) run_req(i, vec[i]);

        // Abort a byte store while it waits on the read data.
        ram[4] = 32'h11223344;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h12;
        req_type  = 3'd2;
        req_wdata = 32'h000000AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort read_en", {31'h0, mem_en}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort mem_en", {31'h0, mem_en}, 32'h0);
        chk("abort ready_in_rst", {31'h0, req_ready}, 32'h0);
        bad_we = 0;
        bad_rsp = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_we) bad_we++;
            if (rsp_valid) bad_rsp++;
        end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_we) bad_we++;
            if (rsp_valid) bad_rsp++;
        end
        chk("abort mem_we", bad_we, 0);
        chk("abort rsp_valid", bad_rsp, 0);
        chk("abort ready", {31'h0, req_ready}, 32'h1);
        chk("abort ram", ram[4], 32'h11223344);

        v = '{0, 32'h12, 3'd4, 32'h0, 0, 32'h0, 32'h00000022, 0, 3, 32'h11223344};
        run_req(99, v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got stuck want finish");
        $fatal(1);
    end

endmodule
